// File: rtl/counter_run_ctrl_if.sv
// counter_run_ctrl_if: control, status and counter-feedback bundle for the run controller.
// Latency: wires only, no state.
// Backpressure: none; every field is a level or single-cycle pulse.
//
// Ports (from the controller's point of view, modport slave):
//   in  start, stop, pause, periodic, period[WIDTH], counting[WIDTH]
//   out cnt_en, cnt_clr, tick, busy, done, start_err, tick_count[TCNT_W]
interface counter_run_ctrl_if #(
  parameter int WIDTH  = 32,
  parameter int TCNT_W = 16
);
  // Requests from software / top level
  logic              start;
  logic              stop;
  logic              pause;
  logic              periodic;
  logic [WIDTH-1:0]  period;
  // Live value fed back from the counter datapath
  logic [WIDTH-1:0]  counting;
  // Counter drive
  logic              cnt_en;
  logic              cnt_clr;
  // Status
  logic              tick;
  logic              busy;
  logic              done;
  logic              start_err;
  logic [TCNT_W-1:0] tick_count;

  // Requester side: issues commands, supplies the counter value, watches status.
  modport master (
    output start, stop, pause, periodic, period, counting,
    input  cnt_en, cnt_clr, tick, busy, done, start_err, tick_count
  );

  // Controller side.
  modport slave (
    input  start, stop, pause, periodic, period, counting,
    output cnt_en, cnt_clr, tick, busy, done, start_err, tick_count
  );
endinterface

// File: rtl/counter_run_ctrl.sv
// counter_run_ctrl: arms and runs the external counter over a programmable period (one-shot/periodic).
// Latency: cnt_en/cnt_clr/busy/done combinational from state; tick/start_err one cycle after the event.
// Backpressure: none; pause freezes the count, stop aborts to IDLE, start is ignored while busy.
//
// Ports:
//   clock      rising-edge clock for all state
//   reset      synchronous, active-high
//   ctl        counter_run_ctrl_if.slave (start/stop/pause/periodic/period/counting in;
//              cnt_en/cnt_clr/tick/busy/done/start_err/tick_count out)
module counter_run_ctrl #(
  parameter int WIDTH  = 32,
  parameter int TCNT_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  counter_run_ctrl_if.slave ctl
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_RUN  = 3'd2,
    S_HOLD = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0]  PER_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [TCNT_W-1:0] TC_ONE  = {{(TCNT_W-1){1'b0}}, 1'b1};
  localparam logic [TCNT_W-1:0] TC_MAX  = {TCNT_W{1'b1}};

  state_t            state_q;
  state_t            state_d;
  logic [WIDTH-1:0]  period_q;
  logic              periodic_q;
  logic              tick_q;
  logic              start_err_q;
  logic [TCNT_W-1:0] tick_count_q;

  logic              cnt_en;
  logic              cnt_clr;
  logic              startable;
  logic              start_ok;
  logic              start_bad;
  logic              expire;
  logic              tick_fire;

  // start is only looked at when nothing is running; stop beats it.
  assign startable = (state_q == S_IDLE) || (state_q == S_DONE);
  assign start_ok  = startable && ctl.start && !ctl.stop && (ctl.period != '0);
  assign start_bad = startable && ctl.start && !ctl.stop && (ctl.period == '0);

  // period_q is never zero while in RUN, so period_q-1 cannot underflow here.
  assign expire    = (state_q == S_RUN) && (ctl.counting == (period_q - PER_ONE));
  // A stop on the expiry cycle swallows the expiry entirely.
  assign tick_fire = expire && !ctl.stop;

  // Next state and counter drive.
  always_comb begin
    state_d = state_q;
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          state_d = S_ARM;
        end
      end

      S_ARM: begin
        cnt_clr = 1'b1;
        state_d = S_RUN;
      end

      S_RUN: begin
        cnt_en = 1'b1;
        if (expire) begin
          // Clear and enable together: the counter treats clear as dominant,
          // so the count wraps straight to 0 on the expiry edge.
          cnt_clr = 1'b1;
          if (!periodic_q) begin
            state_d = S_DONE;
          end else if (ctl.pause) begin
            state_d = S_HOLD;
          end else begin
            state_d = S_RUN;
          end
        end else if (ctl.pause) begin
          state_d = S_HOLD;
        end
      end

      S_HOLD: begin
        if (!ctl.pause) begin
          state_d = S_RUN;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // stop leaves the counter exactly where it is.
    if (ctl.stop) begin
      state_d = S_IDLE;
      cnt_en  = 1'b0;
      cnt_clr = 1'b0;
    end

    // Reset silences the counter drive in the same cycle it is asserted,
    // without waiting for the state register to fall back to IDLE.
    if (reset) begin
      cnt_en  = 1'b0;
      cnt_clr = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      period_q     <= '0;
      periodic_q   <= 1'b0;
      tick_q       <= 1'b0;
      start_err_q  <= 1'b0;
      tick_count_q <= '0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_fire;
      start_err_q <= start_bad;
      if (start_ok) begin
        period_q     <= ctl.period;
        periodic_q   <= ctl.periodic;
        tick_count_q <= '0;
      end else if (tick_fire && (tick_count_q != TC_MAX)) begin
        tick_count_q <= tick_count_q + TC_ONE;
      end
    end
  end

  assign ctl.cnt_en     = cnt_en;
  assign ctl.cnt_clr    = cnt_clr;
  assign ctl.tick       = tick_q;
  assign ctl.start_err  = start_err_q;
  assign ctl.tick_count = tick_count_q;
  assign ctl.busy       = (state_q == S_ARM) || (state_q == S_RUN) || (state_q == S_HOLD);
  assign ctl.done       = (state_q == S_DONE);

  // Sanity properties on the sequencing.
  a_idle_quiet: assert property (@(posedge clock) disable iff (reset)
    (state_q == S_IDLE) |-> (!ctl.cnt_en && !ctl.cnt_clr));

  a_hold_frozen: assert property (@(posedge clock) disable iff (reset)
    (state_q == S_HOLD) |-> (!ctl.cnt_en && !ctl.cnt_clr));

  a_arm_single: assert property (@(posedge clock) disable iff (reset)
    (state_q == S_ARM && !ctl.stop) |=> (state_q == S_RUN));

  a_stop_idle: assert property (@(posedge clock) disable iff (reset)
    ctl.stop |=> (state_q == S_IDLE));

endmodule

// File: tb/tb_counter_run_ctrl.sv
// tb_counter_run_ctrl: directed scenarios plus randomized traffic against a behavioural model.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_counter_run_ctrl;

  localparam int W  = 32;
  localparam int TW = 4;           // narrow so tick_count saturation is reachable quickly
  localparam int TC_SAT = (1 << TW) - 1;

  localparam int P_IDLE = 0;
  localparam int P_ARM  = 1;
  localparam int P_RUN  = 2;
  localparam int P_HOLD = 3;
  localparam int P_DONE = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [W-1:0] cnt_val = '0;

  int errors = 0;
  int checks = 0;

  counter_run_ctrl_if #(.WIDTH(W), .TCNT_W(TW)) bus ();

  counter_run_ctrl #(.WIDTH(W), .TCNT_W(TW)) dut (
    .clock (clock),
    .reset (reset),
    .ctl   (bus)
  );

  always #5 clock = ~clock;

  // Counter datapath: clear dominates enable; reset does not touch it.
  always_ff @(posedge clock) begin
    if (bus.cnt_clr)     cnt_val <= '0;
    else if (bus.cnt_en) cnt_val <= cnt_val + 32'd1;
  end
  assign bus.counting = cnt_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_ph   = P_IDLE;
  logic [31:0] m_per  = '0;
  bit          m_auto = 1'b0;
  int          m_left = 0;      // RUN cycles remaining before the current period expires
  logic [31:0] m_cnt  = '0;
  bit          m_tick = 1'b0;
  bit          m_err  = 1'b0;
  int          m_tc   = 0;

  always @(negedge clock) begin
    bit e_en, e_clr, fire, bad, sok;
    int nph;
    e_en = 0; e_clr = 0; fire = 0; bad = 0; sok = 0; nph = m_ph;

    if (!reset) begin
      if (bus.stop) begin
        nph = P_IDLE;
      end else begin
        case (m_ph)
          P_IDLE, P_DONE: if (bus.start) begin
            if (bus.period != '0) begin sok = 1; nph = P_ARM; end
            else bad = 1;
          end
          P_ARM: begin e_clr = 1; nph = P_RUN; end
          P_RUN: begin
            e_en = 1;
            if (m_left == 1) begin
              fire = 1; e_clr = 1;
              nph = !m_auto ? P_DONE : (bus.pause ? P_HOLD : P_RUN);
            end else if (bus.pause) begin
              nph = P_HOLD;
            end
          end
          P_HOLD: if (!bus.pause) nph = P_RUN;
          default: ;
        endcase
      end
    end

    check("cnt_en",     32'(bus.cnt_en),     32'(e_en));
    check("cnt_clr",    32'(bus.cnt_clr),    32'(e_clr));
    check("busy",       32'(bus.busy),       32'(m_ph == P_ARM || m_ph == P_RUN || m_ph == P_HOLD));
    check("done",       32'(bus.done),       32'(m_ph == P_DONE));
    check("tick",       32'(bus.tick),       32'(m_tick));
    check("start_err",  32'(bus.start_err),  32'(m_err));
    check("tick_count", 32'(bus.tick_count), 32'(m_tc));
    check("counting",   bus.counting,        m_cnt);

    if (reset) begin
      m_ph = P_IDLE; m_per = '0; m_auto = 0; m_tick = 0; m_err = 0; m_tc = 0;
    end else begin
      if (sok) begin
        m_per = bus.period; m_auto = bus.periodic; m_tc = 0; m_left = int'(bus.period);
      end
      if (e_en) m_left = fire ? int'(m_per) : m_left - 1;
      if (fire && m_tc < TC_SAT) m_tc++;
      m_tick = fire;
      m_err  = bad;
      m_ph   = nph;
    end
    m_cnt = e_clr ? 32'd0 : (e_en ? m_cnt + 32'd1 : m_cnt);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] per, input logic auto);
    bus.period   = per;
    bus.periodic = auto;
    bus.start    = 1'b1;
    step();
    bus.start    = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
  endtask

  // Counts edges until tick is seen; an expired bound is a failure.
  task automatic wait_tick(input int bound, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.tick && n < bound);
    if (!bus.tick) begin
      checks++;
      errors++;
      $display("FAIL tick_wait: no tick within %0d cycles", bound);
    end
  endtask

  initial begin
    int n;
    bus.start = 0; bus.stop = 0; bus.pause = 0; bus.periodic = 0; bus.period = '0;
    reset = 1'b1;
    step(); step();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_tc",   32'(bus.tick_count), 32'd0);
    reset = 1'b0;
    step();

    // 1) periodic, period 4
    pulse_start(32'd4, 1'b1);
    check("t1_arm_busy", 32'(bus.busy), 32'd1);
    wait_tick(20, n);  check("t1_first_tick_gap", 32'(n), 32'd5);
    wait_tick(20, n);  check("t1_tick_gap2",      32'(n), 32'd4);
    wait_tick(20, n);  check("t1_tick_gap3",      32'(n), 32'd4);
    check("t1_tick_count", 32'(bus.tick_count), 32'd3);
    check("t1_count_wrap", bus.counting, 32'd0);
    pulse_stop();

    // 2) one-shot, period 5, then re-run from DONE
    pulse_start(32'd5, 1'b0);
    wait_tick(20, n);  check("t2_tick_gap", 32'(n), 32'd6);
    check("t2_done", 32'(bus.done), 32'd1);
    check("t2_busy", 32'(bus.busy), 32'd0);
    check("t2_count", bus.counting, 32'd0);
    step(); step();
    check("t2_no_retick", 32'(bus.tick), 32'd0);
    pulse_start(32'd5, 1'b0);
    check("t2_rearm", 32'(bus.busy), 32'd1);
    wait_tick(20, n);  check("t2_rerun_gap", 32'(n), 32'd6);
    pulse_stop();

    // 3) period 6, pause for three cycles
    pulse_start(32'd6, 1'b1);
    wait_tick(20, n);  check("t3_first_gap", 32'(n), 32'd7);
    step();
    bus.pause = 1'b1;
    step(); step(); step();
    check("t3_held_count", bus.counting, 32'd2);
    bus.pause = 1'b0;
    wait_tick(20, n);  check("t3_paused_gap", 32'(n), 32'd5);
    pulse_stop();

    // 4) stop on the expiry cycle
    pulse_start(32'd3, 1'b1);
    step(); step(); step();
    check("t4_at_expiry", bus.counting, 32'd2);
    pulse_stop();
    check("t4_no_tick", 32'(bus.tick), 32'd0);
    check("t4_idle", 32'(bus.busy), 32'd0);
    check("t4_count_kept", bus.counting, 32'd2);

    // 5) start with period 0
    pulse_start(32'd0, 1'b1);
    check("t5_err", 32'(bus.start_err), 32'd1);
    check("t5_busy", 32'(bus.busy), 32'd0);
    check("t5_en", 32'(bus.cnt_en), 32'd0);
    step();
    check("t5_err_pulse", 32'(bus.start_err), 32'd0);

    // 6) period 1: continuous tick, saturation, reset mid-run
    pulse_start(32'd1, 1'b1);
    for (int i = 0; i < 11; i++) begin
      step();
      if (i >= 1) check("t6_tick_high", 32'(bus.tick), 32'd1);
    end
    check("t6_tick_count", 32'(bus.tick_count), 32'd10);
    for (int i = 0; i < 10; i++) step();
    check("t6_saturated", 32'(bus.tick_count), 32'(TC_SAT));
    reset = 1'b1;
    #1;
    check("t6_rst_en",  32'(bus.cnt_en),  32'd0);
    check("t6_rst_clr", 32'(bus.cnt_clr), 32'd0);
    step();
    check("t6_rst_busy", 32'(bus.busy), 32'd0);
    check("t6_rst_tick", 32'(bus.tick), 32'd0);
    check("t6_rst_tc",   32'(bus.tick_count), 32'd0);
    reset = 1'b0;
    step();

    // Randomized traffic, checked every cycle by the model process.
    for (int i = 0; i < 3000; i++) begin
      bus.start    = ($urandom_range(0, 9) == 0);
      bus.stop     = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) bus.pause = ~bus.pause;
      bus.periodic = ($urandom_range(0, 3) != 0);
      bus.period   = $urandom_range(0, 7);
      reset        = ($urandom_range(0, 299) == 0);
      step();
    end

    bus.start = 0; bus.stop = 0; bus.pause = 0; reset = 0;
    step(); step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
